// File: rtl/or1200_ifq.sv
// ---------------------------------------------------------------------------
// or1200_ifq -- instruction fetch queue between the I-cache/IMMU fetch port
// and decode.
//
// Accepts FETCH_W-instruction fetch beats (partially used beats for
// unaligned branch targets), buffers up to DEPTH instructions with PC and
// exception tag, and presents the head and head+1 instructions for dual
// issue. An erroring beat enqueues a single l.nop carrying the exception
// and blocks further fetch until flushpipe.
//
// Optional feature macro: OR1200_IFQ_BYPASS_EN
//   defined   : an empty queue forwards a beat being pushed straight to the
//               if_* outputs in the same cycle (latency 0).
//   undefined : outputs come from registered queue state only (latency 1).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   icpu_dat_i               fetch beat, lowest address in the top word
//   icpu_ack_i / icpu_err_i  beat valid / beat carries bus or MMU error
//   icpu_adr_i / icpu_tag_i  address of first wanted insn / fetch tag
//   icpu_rdy_o               queue can accept a full beat
//   if_freeze, flushpipe     decode frozen / discard all contents
//   id_take                  instructions consumed this cycle
//   if_insn(2), if_pc(2)     head and head+1 instruction and PC
//   if_valid(2), if_stall    slot valid flags / queue empty
//   except_*                 exception class of the head entry
// ---------------------------------------------------------------------------
module or1200_ifq #(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*FETCH_W-1:0] icpu_dat_i,
  input  logic                  icpu_ack_i,
  input  logic                  icpu_err_i,
  input  logic [31:0]           icpu_adr_i,
  input  logic [3:0]            icpu_tag_i,
  output logic                  icpu_rdy_o,
  input  logic                  if_freeze,
  input  logic                  flushpipe,
  input  logic [1:0]            id_take,
  output logic [31:0]           if_insn,
  output logic [31:0]           if_insn2,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_pc2,
  output logic                  if_valid,
  output logic                  if_valid2,
  output logic                  if_stall,
  output logic                  except_itlbmiss,
  output logic                  except_immufault,
  output logic                  except_ibuserr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int NP_W  = $clog2(FETCH_W + 1);
  localparam int BW    = (FETCH_W < 2) ? 2 : FETCH_W;

  localparam logic [31:0] NOP    = 32'h1500_0000;
  localparam logic [3:0]  TAG_BE = 4'hb;
  localparam logic [3:0]  TAG_PE = 4'hc;
  localparam logic [3:0]  TAG_TE = 4'hd;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             blocked_q, blocked_d;

  logic [31:0] mem_insn [DEPTH];
  logic [29:0] mem_pc   [DEPTH];
  logic [3:0]  mem_tag  [DEPTH];
  logic        mem_exc  [DEPTH];

  logic [OFF_W-1:0]       off;
  logic [32*FETCH_W-1:0]  dat_shift;
  logic                   beat_err;
  logic [3:0]             beat_tag;
  logic                   push;
  logic [NP_W-1:0]        push_n;
  logic [NP_W-1:0]        push_cnt;
  logic [31:0]            beat_insn [BW];
  logic [29:0]            beat_pc   [BW];

  logic [PTR_W-1:0] head1;
  logic             s0_v, s1_v, s0_exc, s1_exc;
  logic [31:0]      s0_insn, s1_insn;
  logic [29:0]      s0_pc, s1_pc;
  logic [3:0]       s0_tag;
  logic [1:0]       nvalid, pop_n;

  logic unused_adr;
  assign unused_adr = ^icpu_adr_i[1:0];

  // Ready looks only at registered state so it never depends on this
  // cycle's pop.
  assign icpu_rdy_o = ~blocked_q & ((DEPTH - int'(count_q)) >= FETCH_W);

  // Beat decode: shifting by the word offset puts the first wanted
  // instruction in the top word, so pushed entry k is always word k.
  always_comb begin
    off       = (FETCH_W > 1) ? icpu_adr_i[OFF_W+1:2] : '0;
    dat_shift = icpu_dat_i << {off, 5'b0};
    beat_err  = icpu_err_i | (icpu_tag_i != 4'h0);
    beat_tag  = (icpu_tag_i == 4'h0) ? TAG_BE : icpu_tag_i;
    push      = icpu_ack_i & icpu_rdy_o & ~flushpipe;
    push_n    = beat_err ? NP_W'(1) : (NP_W'(FETCH_W) - NP_W'(off));
    push_cnt  = push ? push_n : '0;
    for (int k = 0; k < BW; k++) begin
      beat_insn[k] = NOP;
      beat_pc[k]   = icpu_adr_i[31:2] + 30'(k);
    end
    for (int k = 0; k < FETCH_W; k++) begin
      if (!beat_err) beat_insn[k] = dat_shift[32*(FETCH_W-k)-1 -: 32];
    end
  end

  // Output slots
  always_comb begin
    head1   = head_q + PTR_W'(1);
    s0_v    = (count_q != '0);
    s1_v    = (count_q >= CNT_W'(2));
    s0_insn = mem_insn[head_q];
    s0_pc   = mem_pc[head_q];
    s0_tag  = mem_tag[head_q];
    s0_exc  = mem_exc[head_q];
    s1_insn = mem_insn[head1];
    s1_pc   = mem_pc[head1];
    s1_exc  = mem_exc[head1];
`ifdef OR1200_IFQ_BYPASS_EN
    if ((count_q == '0) && push) begin
      s0_v    = 1'b1;
      s0_insn = beat_insn[0];
      s0_pc   = beat_pc[0];
      s0_exc  = beat_err;
      s0_tag  = beat_err ? beat_tag : 4'h0;
      s1_v    = (int'(push_n) >= 2);
      s1_insn = beat_insn[1];
      s1_pc   = beat_pc[1];
      s1_exc  = 1'b0;
    end
`endif
    if_valid  = s0_v;
    // An exception entry must reach decode alone so it is taken precisely.
    if_valid2 = s1_v & ~s0_exc & ~s1_exc;
    if_stall  = ~s0_v;
    if_insn   = if_valid  ? s0_insn : NOP;
    if_pc     = if_valid  ? {s0_pc, 2'b00} : 32'h0;
    if_insn2  = if_valid2 ? s1_insn : NOP;
    if_pc2    = if_valid2 ? {s1_pc, 2'b00} : 32'h0;
    except_itlbmiss  = s0_v & s0_exc & (s0_tag == TAG_TE);
    except_immufault = s0_v & s0_exc & (s0_tag == TAG_PE);
    except_ibuserr   = s0_v & s0_exc & (s0_tag == TAG_BE);
  end

  // Pop and pointer next-state
  always_comb begin
    nvalid    = if_valid2 ? 2'd2 : {1'b0, if_valid};
    pop_n     = if_freeze ? 2'd0 : ((id_take < nvalid) ? id_take : nvalid);
    head_d    = head_q + PTR_W'(pop_n);
    tail_d    = tail_q + PTR_W'(push_cnt);
    count_d   = count_q + CNT_W'(push_cnt) - CNT_W'(pop_n);
    blocked_d = blocked_q | (push & beat_err);
    if (flushpipe) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      blocked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      blocked_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      blocked_q <= blocked_d;
    end
  end

  // Storage needs no reset: slots outside head..count are never presented.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (push && (k < int'(push_n))) begin
        mem_insn[tail_q + PTR_W'(k)] <= beat_insn[k];
        mem_pc[tail_q + PTR_W'(k)]   <= beat_pc[k];
        mem_tag[tail_q + PTR_W'(k)]  <= beat_err ? beat_tag : 4'h0;
        mem_exc[tail_q + PTR_W'(k)]  <= beat_err;
      end
    end
  end

endmodule

// File: tb/tb_or1200_ifq.sv
module tb_or1200_ifq;
  localparam int FW = 2;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP  = 32'h1500_0000;
  localparam logic [3:0]  T_BE = 4'hb;
  localparam logic [3:0]  T_PE = 4'hc;
  localparam logic [3:0]  T_TE = 4'hd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] dat = '0;
  logic        ack = 1'b0, err = 1'b0, frz = 1'b0, flush = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  tag = '0;
  logic [1:0]  take = '0;
  logic        rdy, v, v2, stall, e_tlb, e_mmu, e_bus;
  logic [31:0] insn, insn2, pc, pc2;

  or1200_ifq #(.FETCH_W(FW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .icpu_dat_i(dat), .icpu_ack_i(ack), .icpu_err_i(err),
    .icpu_adr_i(adr), .icpu_tag_i(tag), .icpu_rdy_o(rdy),
    .if_freeze(frz), .flushpipe(flush), .id_take(take),
    .if_insn(insn), .if_insn2(insn2), .if_pc(pc), .if_pc2(pc2),
    .if_valid(v), .if_valid2(v2), .if_stall(stall),
    .except_itlbmiss(e_tlb), .except_immufault(e_mmu), .except_ibuserr(e_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  tag;
  } ent_t;

  typedef struct {
    logic v, v2, stall, rdy, tlb, mmu, bus;
    logic [31:0] insn, insn2, pc, pc2;
  } exp_t;

  ent_t mq[$];
  bit   mblocked = 0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected outputs straight from the queue contents.
  function automatic exp_t model_out();
    exp_t e;
    e.v = mq.size() >= 1;
    e.v2 = 1'b0;
    if (mq.size() >= 2) e.v2 = !mq[0].exc && !mq[1].exc;
    e.insn = NOP; e.pc = 0; e.insn2 = NOP; e.pc2 = 0;
    e.tlb = 0; e.mmu = 0; e.bus = 0;
    if (e.v) begin
      e.insn = mq[0].insn; e.pc = mq[0].pc;
      e.tlb = mq[0].exc && mq[0].tag == T_TE;
      e.mmu = mq[0].exc && mq[0].tag == T_PE;
      e.bus = mq[0].exc && mq[0].tag == T_BE;
    end
    if (e.v2) begin e.insn2 = mq[1].insn; e.pc2 = mq[1].pc; end
    e.stall = !e.v;
    e.rdy = !mblocked && (DEPTH - mq.size() >= FW);
    return e;
  endfunction

  task automatic model_step();
    int nv, npop;
    bit mrdy;
    ent_t x;
    ent_t newe[$];
    nv = 0;
    if (mq.size() >= 1) nv = 1;
    if (mq.size() >= 2 && !mq[0].exc && !mq[1].exc) nv = 2;
    npop = frz ? 0 : ((int'(take) < nv) ? int'(take) : nv);
    mrdy = !mblocked && (DEPTH - mq.size() >= FW);
    if (flush) begin
      mq.delete();
      mblocked = 0;
      return;
    end
    if (ack && mrdy) begin
      if (err || tag != 4'h0) begin
        x.insn = NOP; x.pc = {adr[31:2], 2'b00}; x.exc = 1;
        x.tag = (tag == 4'h0) ? T_BE : tag;
        newe.push_back(x);
        mblocked = 1;
      end else begin
        for (int w = int'(adr[2]); w < FW; w++) begin
          x.insn = 32'(dat >> (32 * (FW - 1 - w)));
          x.pc = {adr[31:2], 2'b00} + 32'(4 * (w - int'(adr[2])));
          x.exc = 0; x.tag = 0;
          newe.push_back(x);
        end
      end
    end
    repeat (npop) void'(mq.pop_front());
    foreach (newe[i]) mq.push_back(newe[i]);
  endtask

  // Called at posedge+1: record what the DUT shows now, drive, clock, model.
  task automatic step(input logic a, input logic e, input logic [31:0] ad, input logic [63:0] d,
                      input logic [3:0] tg, input logic fz, input logic fl, input logic [1:0] tk);
    exp_q.push_back(model_out());
    ack = a; err = e; adr = ad; dat = d; tag = tg; frz = fz; flush = fl; take = tk;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic [1:0] tk);
    step(0, 0, 0, 0, 0, 0, 0, tk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", v, 0);
    chk("rst_stall", stall, 1);
    chk("rst_rdy", rdy, 1);
    chk("rst_insn", insn, NOP);
    mq.delete();
    mblocked = 0;
    exp_q.push_back(model_out());
    ack = 0; err = 0; flush = 0; frz = 0; take = 0; tag = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: compares each recorded expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_valid", v, e.v);
        chk("sb_valid2", v2, e.v2);
        chk("sb_stall", stall, e.stall);
        chk("sb_rdy", rdy, e.rdy);
        chk("sb_insn", insn, e.insn);
        chk("sb_pc", pc, e.pc);
        chk("sb_insn2", insn2, e.insn2);
        chk("sb_pc2", pc2, e.pc2);
        chk("sb_itlb", e_tlb, e.tlb);
        chk("sb_immu", e_mmu, e.mmu);
        chk("sb_ibus", e_bus, e.bus);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int budget;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // aligned beat
    step(1, 0, 32'h100, 64'h1234567890ABCDEF, 0, 0, 0, 0);
    chk("al_insn", insn, 32'h12345678);
    chk("al_pc", pc, 32'h100);
    chk("al_insn2", insn2, 32'h90ABCDEF);
    chk("al_pc2", pc2, 32'h104);
    chk("al_v2", v2, 1);
    idle(2);
    chk("al_empty", v, 0);

    // unaligned beat, then error beat behind it
    step(1, 0, 32'h104, 64'h1234567890ABCDEF, 0, 0, 0, 0);
    chk("ua_insn", insn, 32'h90ABCDEF);
    chk("ua_pc", pc, 32'h104);
    chk("ua_v2", v2, 0);
    step(1, 1, 32'h200, 64'hDEAD_BEEF_DEAD_BEEF, T_BE, 0, 0, 0);
    chk("er_v2", v2, 0);
    chk("er_rdy", rdy, 0);
    idle(2);
    chk("er_ibus", e_bus, 1);
    chk("er_insn", insn, NOP);
    chk("er_pc", pc, 32'h200);
    idle(1);
    chk("er_popped", v, 0);
    idle(0);
    chk("er_blocked", rdy, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("er_flush_rdy", rdy, 1);

    // fill to full
    for (int k = 0; k < 4; k++) begin
      d = {32'hC0DE_0000 + 32'(2*k), 32'hC0DE_0000 + 32'(2*k+1)};
      step(1, 0, 32'h400 + 32'(8*k), d, 0, 0, 0, 0);
    end
    chk("full_rdy", rdy, 0);
    step(1, 0, 32'h420, 64'h1111_1111_2222_2222, 0, 0, 0, 0);
    chk("full_nopush", insn, 32'hC0DE_0000);
    step(0, 0, 0, 0, 0, 0, 0, 2);
    chk("drain_rdy", rdy, 1);
    chk("drain_insn", insn, 32'hC0DE_0002);
    chk("drain_pc", pc, 32'h408);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // flush coincident with ack and take on a 4-deep queue
    step(1, 0, 32'h500, 64'hAAAA_0001_AAAA_0002, 0, 0, 0, 0);
    step(1, 0, 32'h508, 64'hAAAA_0003_AAAA_0004, 0, 0, 0, 0);
    step(1, 0, 32'h600, 64'hBBBB_0001_BBBB_0002, 0, 0, 1, 2);
    chk("fl_valid", v, 0);
    chk("fl_rdy", rdy, 1);
    idle(2);
    chk("fl_never", v, 0);

    // freeze holds the head
    step(1, 0, 32'h700, 64'hCCCC_0001_CCCC_0002, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 2);
    chk("frz_pc", pc, 32'h700);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // PE tag without err, TE tag with err
    step(1, 0, 32'h804, 64'h0, T_PE, 0, 0, 0);
    chk("pe_immu", e_mmu, 1);
    chk("pe_ibus", e_bus, 0);
    chk("pe_pc", pc, 32'h804);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 32'h900, 64'h0, T_TE, 0, 0, 0);
    chk("te_itlb", e_tlb, 1);
    chk("te_ibus", e_bus, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic a, e, fl, fz;
      logic [3:0] tg;
      logic [31:0] ad;
      int r;
      if (i == 1500) begin
        step(1, 0, 32'h1000, 64'h5555_6666_7777_8888, 0, 0, 0, 0);
        do_reset();
      end
      a = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 39);
      e = (r <= 1);
      tg = (r == 1) ? T_BE : (r == 2) ? T_PE : (r == 3) ? T_TE : 4'h0;
      fl = ($urandom_range(0, 19) == 0);
      fz = ($urandom_range(0, 9) == 0);
      ad = {$urandom(), 2'b00};
      step(a, e, ad, {$urandom(), $urandom()}, tg, fz, fl, 2'($urandom_range(0, 3)));
    end

    idle(0);
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/or1200_ifq.md
# or1200_ifq

Parametrised instruction fetch queue between the instruction-cache/IMMU fetch port and decode. It accepts FETCH_W-instruction-wide fetch beats, including partially used beats for unaligned branch targets. It buffers up to DEPTH instructions with their PCs and exception tags, and presents up to two instructions per cycle for dual issue. It replaces the fixed two-instruction fetch register path and adds buffering, alignment handling and precise exception blocking.

## Interface
- FETCH_W, 2, instructions per fetch beat (1, 2 or 4).
- DEPTH, 8, queue entries; power of two, ≥ 2*FETCH_W.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- icpu_dat_i  in  32*FETCH_W  fetch data; lowest-address instruction in the most-significant word.
- icpu_ack_i  in  1  fetch beat valid.
- icpu_err_i  in  1  fetch bus/translation error on this beat.
- icpu_adr_i  in  32  address of the first wanted instruction.
- icpu_tag_i  in  4  fetch tag (`OR1200_ITAG_PE / _BE / _TE).
- icpu_rdy_o  out  1  queue can accept a full beat.
- if_freeze  in  1  decode frozen; id_take ignored.
- flushpipe  in  1  discard all contents.
- id_take  in  2  instructions consumed this cycle (0..2).
- if_insn, if_insn2  out  32  head and head+1 instructions.
- if_pc, if_pc2  out  32  their PCs.
- if_valid, if_valid2  out  1  slot valid.
- if_stall  out  1  queue empty.
- except_itlbmiss, except_immufault, except_ibuserr  out  1  head entry's exception.

## Operation
- Entry = {insn[31:0], pc[31:2], tag[3:0], exc}. Storage is a circular buffer with head and tail pointers that wrap mod DEPTH. count is $clog2(DEPTH+1) bits.
- Push when icpu_ack_i & icpu_rdy_o & ~flushpipe.
  - Offset off = icpu_adr_i[$clog2(FETCH_W)+1:2].
  - Normal beat: push words off..FETCH_W-1, giving FETCH_W-off entries, with pc = {icpu_adr_i[31:2]+k, 2'b00}.
  - Error beat (icpu_err_i, or icpu_tag_i ≠ 0): push one entry at icpu_adr_i with insn = 32'h1500_0000 (l.nop), exc=1 and the tag; icpu_err_i with tag 0 is recorded as BE. The block flag is then set.
- icpu_rdy_o = ~blocked & (DEPTH - count ≥ FETCH_W), computed from registered state only; a same-cycle pop does not count.
- Output validity:
  - if_valid = count≥1.
  - if_valid2 = count≥2 & ~exc[head] & ~exc[head+1].
  - Invalid slots drive insn 32'h1500_0000 and pc 0.
- Pop count = freeze ? 0 : min(id_take, number of valid slots); extra takes are ignored.
- Exception outputs follow the head tag and are valid only when if_valid:
  - TE → itlbmiss.
  - PE → immufault.
  - BE → ibuserr.
- Push and pop in the same cycle are allowed, with count += pushed − popped.
- flushpipe: head, tail and count go to 0 and blocked is cleared on the next edge. A push or pop in the same cycle is discarded.
- Reset mid-operation: state clears immediately (asynchronous).

## Timing
- Reset values: icpu_rdy_o=1; if_valid=if_valid2=0; if_stall=1; if_insn=if_insn2=32'h1500_0000; if_pc=if_pc2=0; all except_*=0.
- Push-to-output latency is 1 cycle: a beat acked at edge n is visible after edge n.
- Pop takes effect at the clock edge.
- When full (count=DEPTH), icpu_rdy_o=0 and an ack in that state is a protocol violation, so no push occurs.
- When empty, id_take is ignored.
- After an error beat, icpu_rdy_o stays 0 until flushpipe, even after the exception entry is popped.

## Configuration
- OR1200_IFQ_BYPASS_EN defined: when the queue is empty and a push occurs, the first two pushed instructions drive the outputs combinationally in the same cycle (latency 0), and id_take may consume them in that cycle. Error beats bypass too, with their except_* output.
- Undefined: 1-cycle latency only. There is no combinational path from icpu_* to the if_* outputs.

## Test plan
All scenarios use FETCH_W=2, DEPTH=8, bypass undefined.
- Reset asserted, then released → if_valid=0, if_stall=1, icpu_rdy_o=1, if_insn=32'h15000000.
- Ack at adr 0x100 with dat 64'h1234567890ABCDEF → next cycle if_insn=32'h12345678, pc 0x100; if_insn2=32'h90ABCDEF, pc 0x104; both valid.
- Unaligned ack at adr 0x104, same data → count=1, if_insn=32'h90ABCDEF, pc 0x104, if_valid2=0.
- Ack with icpu_err_i=1 and tag BE at adr 0x200, behind one good entry → if_valid2=0. After one take, except_ibuserr=1 and if_insn=32'h15000000. icpu_rdy_o stays 0 until flushpipe, then returns to 1.
- Four aligned acks with id_take=0 → count=8, icpu_rdy_o=0. Then id_take=2 → icpu_rdy_o=1 next cycle, with the next instructions in order.
- flushpipe coincident with an ack and id_take=2 on a 4-deep queue → next cycle if_valid=0, count=0, and the pushed data is never presented.
